// File: rtl/shift_cmd_issuer_if.sv
// shift_cmd_issuer_if: command input, shifter drive/result and result output signals of shift_cmd_issuer.
interface shift_cmd_issuer_if #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_dir;
    logic [DATA_W-1:0]  sh_data;
    logic [SHIFT_W-1:0] sh_shift;
    logic               sh_dir;
    logic [DATA_W-1:0]  sh_result;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [SHIFT_W-1:0] out_shift;
    logic               out_dir;

    modport master (
        output in_valid, in_data, in_shift, in_dir, sh_result, out_ready,
        input  in_ready, sh_data, sh_shift, sh_dir, out_valid, out_data, out_shift, out_dir
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_dir, sh_result, out_ready,
        output in_ready, sh_data, sh_shift, sh_dir, out_valid, out_data, out_shift, out_dir
    );
endinterface

// File: rtl/shift_cmd_issuer.sv
// shift_cmd_issuer: FIFO-buffered command issuer with registered stages around a combinational shifter.
// Optional ZERO_BYPASS_EN: zero-amount commands skip the shifter and land in out_* one cycle earlier.
module shift_cmd_issuer #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4,
    parameter int DEPTH   = 4
) (
    input logic               clk,
    input logic               rst,
    shift_cmd_issuer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  fifo_data_q  [DEPTH];
    logic [SHIFT_W-1:0] fifo_shift_q [DEPTH];
    logic               fifo_dir_q   [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic [DATA_W-1:0]  sh_data_q, sh_data_d, out_data_q, out_data_d;
    logic [SHIFT_W-1:0] sh_shift_q, sh_shift_d, out_shift_q, out_shift_d;
    logic               sh_dir_q, sh_dir_d, out_dir_q, out_dir_d;
    logic               out_valid_q, out_valid_d;
    logic               push, pop, has_cmd;
    logic [DATA_W-1:0]  head_data;
    logic [SHIFT_W-1:0] head_shift;
    logic               head_dir;

    assign bus.in_ready  = ~rst & (count_q != FULL);
    assign push          = bus.in_valid & bus.in_ready;
    assign has_cmd       = count_q != '0;
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_shift    = fifo_shift_q[rd_ptr_q];
    assign head_dir      = fifo_dir_q[rd_ptr_q];
    assign bus.sh_data   = sh_data_q;
    assign bus.sh_shift  = sh_shift_q;
    assign bus.sh_dir    = sh_dir_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_dir   = out_dir_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q]  <= bus.in_data;
            fifo_shift_q[wr_ptr_q] <= bus.in_shift;
            fifo_dir_q[wr_ptr_q]   <= bus.in_dir;
        end
    end

    // The head entry stays in the FIFO until its result is captured, so capacity is DEPTH plus the output register.
    always_comb begin
        state_d     = state_q;
        sh_data_d   = sh_data_q;
        sh_shift_d  = sh_shift_q;
        sh_dir_d    = sh_dir_q;
        out_data_d  = out_data_q;
        out_shift_d = out_shift_q;
        out_dir_d   = out_dir_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        if (state_q == DRIVE) begin
            out_data_d  = bus.sh_result;
            out_shift_d = sh_shift_q;
            out_dir_d   = sh_dir_q;
            out_valid_d = 1'b1;
            pop         = 1'b1;
            state_d     = RESULT;
        end else if (state_q == IDLE || bus.out_ready) begin
            out_valid_d = 1'b0;
            if (!has_cmd) begin
                state_d = IDLE;
            end
`ifdef ZERO_BYPASS_EN
            else if (head_shift == '0) begin
                out_data_d  = head_data;
                out_shift_d = '0;
                out_dir_d   = head_dir;
                out_valid_d = 1'b1;
                pop         = 1'b1;
                state_d     = RESULT;
            end
`endif
            else begin
                sh_data_d  = head_data;
                sh_shift_d = head_shift;
                sh_dir_d   = head_dir;
                state_d    = DRIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sh_data_q   <= '0;
            sh_shift_q  <= '0;
            sh_dir_q    <= 1'b0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_dir_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q     <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            sh_data_q   <= sh_data_d;
            sh_shift_q  <= sh_shift_d;
            sh_dir_q    <= sh_dir_d;
            out_data_q  <= out_data_d;
            out_shift_q <= out_shift_d;
            out_dir_q   <= out_dir_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_shift_cmd_issuer.sv
// tb_shift_cmd_issuer: scenario tasks plus randomized traffic against a queue-based reference of shift_cmd_issuer.
module tb_shift_cmd_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    logic [20:0] exp_q[$];

    shift_cmd_issuer_if #(.DATA_W(16), .SHIFT_W(4)) bus ();

    shift_cmd_issuer #(.DATA_W(16), .SHIFT_W(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the team's 16-bit barrel shifter: logical shift, dir=1 left.
    assign bus.sh_result = bus.sh_dir ? (bus.sh_data << bus.sh_shift) : (bus.sh_data >> bus.sh_shift);

    always #5 clk = ~clk;

    // Expected output triple {dir, shift, result} for a command packed as {dir, shift, data}.
    function automatic logic [20:0] ref_out(logic [20:0] e);
        logic [15:0] r;
        r = e[20] ? (e[15:0] << e[19:16]) : (e[15:0] >> e[19:16]);
        return {e[20], e[19:16], r};
    endfunction

    function automatic logic [20:0] got_out();
        return {bus.out_dir, bus.out_shift, bus.out_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(logic [15:0] d, logic [3:0] s, logic dir);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shift = s;
        bus.in_dir   = dir;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shift = '0; bus.in_dir = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_shift, bus.out_dir} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got rdy=%b ov=%b od=%h os=%h odir=%b, want all 0",
                bus.in_ready, bus.out_valid, bus.out_data, bus.out_shift, bus.out_dir);
        end
        n_tests++;
        if ({bus.sh_data, bus.sh_shift, bus.sh_dir} !== '0) begin
            n_fail++; $display("FAIL reset_sh: got %h/%h/%b, want 0", bus.sh_data, bus.sh_shift, bus.sh_dir);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got rdy=%b ov=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single(string name, logic [15:0] d, logic [3:0] s, logic dir, logic [15:0] want);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready: got %b want 1", name, bus.in_ready);
        end
        push_cmd(d, s, dir);
        tick();
        n_tests++;
        if ({bus.sh_data, bus.sh_shift, bus.sh_dir, bus.out_valid} !== {d, s, dir, 1'b0}) begin
            n_fail++; $display("FAIL %s_sh_E1: got %h/%h/%b ov=%b want %h/%h/%b ov=0",
                name, bus.sh_data, bus.sh_shift, bus.sh_dir, bus.out_valid, d, s, dir);
        end
        tick();
        n_tests++;
        if ({bus.out_valid, bus.out_data, bus.out_shift, bus.out_dir} !== {1'b1, want, s, dir}) begin
            n_fail++; $display("FAIL %s_out_E2: got ov=%b %h/%h/%b want ov=1 %h/%h/%b",
                name, bus.out_valid, bus.out_data, bus.out_shift, bus.out_dir, want, s, dir);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_consumed: out_valid got %b want 0", name, bus.out_valid);
        end
    endtask

    task automatic test_zero_shift();
        logic [20:0] sh_prev;
        sh_prev = {bus.sh_dir, bus.sh_shift, bus.sh_data};
        push_cmd(16'hABCD, 4'd0, 1'b1);
        tick();
`ifdef ZERO_BYPASS_EN
        n_tests++;
        if ({bus.out_valid, got_out()} !== {1'b1, 1'b1, 4'd0, 16'hABCD}) begin
            n_fail++; $display("FAIL zero_bypass_E1: got ov=%b out=%h want ov=1 out=%h",
                bus.out_valid, got_out(), {1'b1, 4'd0, 16'hABCD});
        end
        n_tests++;
        if ({bus.sh_dir, bus.sh_shift, bus.sh_data} !== sh_prev) begin
            n_fail++; $display("FAIL zero_bypass_sh: got %h want unchanged %h",
                {bus.sh_dir, bus.sh_shift, bus.sh_data}, sh_prev);
        end
`else
        n_tests++;
        if ({bus.out_valid, bus.sh_dir, bus.sh_shift, bus.sh_data} !== {1'b0, 1'b1, 4'd0, 16'hABCD}) begin
            n_fail++; $display("FAIL zero_drive_E1: got ov=%b sh=%h want ov=0 sh=%h (prev %h)",
                bus.out_valid, {bus.sh_dir, bus.sh_shift, bus.sh_data}, {1'b1, 4'd0, 16'hABCD}, sh_prev);
        end
        tick();
        n_tests++;
        if ({bus.out_valid, got_out()} !== {1'b1, 1'b1, 4'd0, 16'hABCD}) begin
            n_fail++; $display("FAIL zero_drive_E2: got ov=%b out=%h want ov=1 out=%h",
                bus.out_valid, got_out(), {1'b1, 4'd0, 16'hABCD});
        end
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_consumed: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] cmds[6];
        logic [20:0] held;
        int k = 0;
        int got = 0;
        int last = -1;
        exp_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            cmds[i] = {1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 16'(i * 16'h1111 + $urandom_range(0, 15))};
        for (int c = 0; c < 14; c++) begin
            bus.in_valid = 1'b1;
            {bus.in_dir, bus.in_shift, bus.in_data} = cmds[k];
            if (bus.in_ready && k < 6) begin exp_q.push_back(cmds[k]); k++; end
            tick();
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (k !== 5 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_capacity: accepted %0d rdy=%b, want 5 rdy=0", k, bus.in_ready);
        end
        held = got_out();
        tick(); tick(); tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || got_out() !== held || held !== ref_out(cmds[0])) begin
            n_fail++; $display("FAIL bp_stall_stable: got ov=%b out=%h held=%h want %h",
                bus.out_valid, got_out(), held, ref_out(cmds[0]));
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (bus.out_valid) begin
                n_tests++;
                if (exp_q.size() == 0 || got_out() !== ref_out(exp_q[0])) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", got, got_out(),
                        exp_q.size() ? ref_out(exp_q[0]) : 21'h0);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
                if (last >= 0) begin
                    n_tests++;
                    if (c - last !== 2) begin
                        n_fail++; $display("FAIL bp_rate[%0d]: spacing got %0d want 2", got, c - last);
                    end
                end
                last = c;
                got++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (got !== 5) begin
            n_fail++; $display("FAIL bp_drain: got %0d results want 5", got);
        end
    endtask

    task automatic test_simultaneous();
        logic [20:0] c6;
        int got = 0;
        exp_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 16'($urandom)});
            push_cmd(exp_q[i][15:0], exp_q[i][19:16], exp_q[i][20]);
        end
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sim_full: got rdy=%b ov=%b want 0/1", bus.in_ready, bus.out_valid);
        end
        n_tests++;
        if (got_out() !== ref_out(exp_q[0])) begin
            n_fail++; $display("FAIL sim_first: got %h want %h", got_out(), ref_out(exp_q[0]));
        end
        void'(exp_q.pop_front());
        c6 = {1'b1, 4'd3, 16'h1234};
        exp_q.push_back(c6);
        bus.in_valid = 1'b1;
        {bus.in_dir, bus.in_shift, bus.in_data} = c6;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL sim_after_hs: got rdy=%b ov=%b want 0/0", bus.in_ready, bus.out_valid);
        end
        tick();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sim_after_pop: got rdy=%b ov=%b want 1/1", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL sim_refill: got rdy=%b want 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (bus.out_valid) begin
                n_tests++;
                if (exp_q.size() == 0 || got_out() !== ref_out(exp_q[0])) begin
                    n_fail++; $display("FAIL sim_order[%0d]: got %h want %h", got, got_out(),
                        exp_q.size() ? ref_out(exp_q[0]) : 21'h0);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
                got++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (got !== 5) begin
            n_fail++; $display("FAIL sim_count: got %0d results want 5", got);
        end
    endtask

    task automatic test_random();
        logic [20:0] cmd, held;
        logic stalled;
        exp_q.delete();
        for (int c = 0; c < 500; c++) begin
            cmd = {1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), 16'($urandom)};
            bus.in_valid = 1'($urandom_range(0, 1));
            {bus.in_dir, bus.in_shift, bus.in_data} = cmd;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.in_valid && bus.in_ready) exp_q.push_back(cmd);
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (exp_q.size() == 0 || got_out() !== ref_out(exp_q[0])) begin
                    n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, got_out(),
                        exp_q.size() ? ref_out(exp_q[0]) : 21'h0);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = got_out();
            tick();
            if (stalled) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || got_out() !== held) begin
                    n_fail++; $display("FAIL rnd_stall@%0d: got ov=%b %h want 1 %h", c, bus.out_valid, got_out(), held);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            if (bus.out_valid) begin
                n_tests++;
                if (got_out() !== ref_out(exp_q[0])) begin
                    n_fail++; $display("FAIL rnd_drain: got %h want %h", got_out(), ref_out(exp_q[0]));
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        tick(); tick();
        n_tests++;
        if (exp_q.size() !== 0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_leftover: %0d pending ov=%b want 0/0", exp_q.size(), bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen_valid = 1'b0;
        bus.out_ready = 1'b0;
        push_cmd(16'h8001, 4'd1, 1'b0);
        push_cmd(16'h0F0F, 4'd2, 1'b1);
        push_cmd(16'h3C3C, 4'd0, 1'b0);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus.in_ready, bus.out_valid, got_out(), bus.sh_data, bus.sh_shift, bus.sh_dir} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: rdy=%b ov=%b out=%h sh=%h/%h/%b want all 0",
                bus.in_ready, bus.out_valid, got_out(), bus.sh_data, bus.sh_shift, bus.sh_dir);
        end
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_valid |= bus.out_valid;
        end
        n_tests++;
        if (seen_valid !== 1'b0 || bus.sh_data !== 16'h0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_stale: ov_seen=%b sh_data=%h rdy=%b want 0/0000/1",
                seen_valid, bus.sh_data, bus.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single("right", 16'hF00F, 4'd4, 1'b0, 16'h0F00);
        test_single("left", 16'h00F1, 4'd8, 1'b1, 16'hF100);
        test_zero_shift();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/shift_cmd_issuer.md
Name: shift_cmd_issuer

Overview:
Upstream command stage for the team's 16-bit combinational barrel shifter.
- Accepts shift commands (data, amount, direction) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the shifter's data/shift/dir inputs from registers and captures the shifter's result into an output register.
- Presents each result downstream over a valid/ready handshake, so the combinational shifter sits between two register stages with flow control.

Parameters:
DATA_W, 16, data width (matches shifter data/result width)
SHIFT_W, 4, shift-amount width (matches shifter shift input)
DEPTH, 4, command FIFO entries; power of two, >=2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  command present
in_ready  out  1  FIFO can accept
in_data  in  DATA_W  operand
in_shift  in  SHIFT_W  shift amount
in_dir  in  1  1=left, 0=right
sh_data  out  DATA_W  registered, to shifter data
sh_shift  out  SHIFT_W  registered, to shifter shift
sh_dir  out  1  registered, to shifter dir
sh_result  in  DATA_W  combinational result from shifter
out_valid  out  1  result present
out_ready  in  1  downstream accepts
out_data  out  DATA_W  shifted result
out_shift  out  SHIFT_W  amount echo for the command in out_data
out_dir  out  1  direction echo for the command in out_data

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs zero (in_ready=0 while rst high, 1 the cycle after); FIFO count=0, pointers=0, state=IDLE. Reset mid-operation discards FIFO contents and any pending out_data.
- FIFO:
  - push = in_valid & in_ready.
  - in_ready = (count != DEPTH).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - in_valid while full is ignored.
- FSM states: IDLE, DRIVE, RESULT.
  - IDLE:
    - If count!=0: load sh_* from FIFO head, go to DRIVE.
    - Else hold; sh_* keep last values.
  - DRIVE (sh_result now valid from registered inputs):
    - out_data<=sh_result; out_shift<=sh_shift; out_dir<=sh_dir; out_valid<=1.
    - Pop head; go to RESULT.
  - RESULT:
    - Hold out_* stable while out_ready=0.
    - On out_ready=1: out_valid<=0. If count!=0, load sh_* from head and go to DRIVE; else go to IDLE.
    - A command pushed in the same cycle as the out_ready handshake, into an empty FIFO, is not visible until the next cycle.
- Latency:
  - Command pushed at edge E0 into an empty, idle block: sh_* valid after E1, out_valid high after E2.
  - Throughput: one command per 2 cycles with out_ready held high.
- Capacity: DEPTH FIFO entries plus one result in the output register. With out_ready=0, in_ready drops after DEPTH+1 accepted commands.
- No arithmetic on data; amount and direction are passed unmodified. The result is exactly what the shifter returns.

Optional Feature:
ZERO_BYPASS_EN
- Defined: when the FSM would load sh_* (from IDLE, or from RESULT with out_ready=1) and head in_shift==0:
  - out_data<=head data, out_shift<=0, out_dir<=head dir, out_valid<=1.
  - Pop; go to RESULT, skipping DRIVE.
  - sh_* are not updated.
  - Latency for zero shifts: out_valid high after E1.
- Undefined: zero-amount commands take the normal DRIVE path through the shifter, with 2-cycle latency.

Test Plan:
- Bench instantiates the team's 16-bit barrel shifter on the sh_* and sh_result ports.
- Reset: assert rst 2 cycles mid-traffic -> all outputs 0, state IDLE, FIFO empty, no stale out_valid after release.
- Single right shift: in_data=0xF00F, in_shift=4, in_dir=0 pushed at E0 -> sh_*=0xF00F/4/0 after E1; out_valid=1, out_data=0x0F00, out_shift=4, out_dir=0 after E2.
- Single left shift: 0x00F1, shift=8, dir=1 -> out_data=0xF100 two cycles after accept.
- Backpressure: out_ready=0, in_valid held with 6 distinct commands -> exactly 5 accepted, then in_ready=0. Raise out_ready -> 5 results in push order, one per 2 cycles, out_data stable while stalled.
- Simultaneous events: FIFO full, out_ready=1 and in_valid=1 in the same cycle as a pop -> count stays DEPTH-1 then returns to DEPTH, no command lost or duplicated.
- Zero shift 0xABCD, shift=0: with ZERO_BYPASS_EN -> out_data=0xABCD after E1 and sh_* unchanged; without ZERO_BYPASS_EN -> out_data=0xABCD after E2.
